// File: rtl/int_muldiv_unit_if.sv
// Request/response bundle between the datapath control and the
// iterative multiply/divide unit: operands, start/op, MTHI/MTLO writes,
// busy/done/dz status and the HI/LO result registers.
interface int_muldiv_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] T;
    logic             HI_wr;
    logic             LO_wr;
    logic [WIDTH-1:0] D;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    // Control side drives requests and reads status/results.
    modport master (
        output start, op, S, T, HI_wr, LO_wr, D,
        input  busy, done, dz, HI, LO
    );

    // The unit consumes requests and owns status/results.
    modport slave (
        input  start, op, S, T, HI_wr, LO_wr, D,
        output busy, done, dz, HI, LO
    );
endinterface

// File: rtl/int_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Operands are reduced to
// magnitudes on acceptance, a radix-2 shift-add multiply or restoring
// divide runs for WIDTH steps, and the FIX state sign-corrects the result
// into HI/LO with a one-cycle done pulse (latency WIDTH+1).
// Optional feature macro: MULDIV_DIVZERO_FAST_EN -- when defined, a
// divide by zero skips the iteration, completes one cycle after
// acceptance with dz=1 and leaves HI/LO untouched.
module int_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    int_muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             neg_q;     // product sign for multiply, quotient sign for divide
    logic             neg_r;     // remainder sign follows the dividend
    logic             div_zero;
    logic             skip_wr;
    logic [WIDTH-1:0] acc;       // upper product half / partial remainder
    logic [WIDTH-1:0] lo_acc;    // multiplier bits / dividend bits -> quotient
    logic [WIDTH-1:0] opb;       // multiplicand / divisor magnitude

    logic             s_neg, t_neg, fast_dz;
    logic [WIDTH-1:0] s_mag, t_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // Operand conditioning: signed ops work on magnitudes and remember signs.
    // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
    always_comb begin
        s_neg = ~bus.op[0] & bus.S[WIDTH-1];
        t_neg = ~bus.op[0] & bus.T[WIDTH-1];
        s_mag = s_neg ? -bus.S : bus.S;
        t_mag = t_neg ? -bus.T : bus.T;
    end

    // Divide-by-zero shortcut decision at acceptance time.
`ifdef MULDIV_DIVZERO_FAST_EN
    always_comb fast_dz = bus.op[1] && (bus.T == '0);
`else
    always_comb fast_dz = 1'b0;
`endif

    // One radix-2 step: conditional add for multiply, trial subtract for divide.
    always_comb begin
        mul_sum   = lo_acc[0] ? ({1'b0, acc} + {1'b0, opb}) : {1'b0, acc};
        div_shift = {acc, lo_acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
    end

    // Sign correction of the finished magnitudes. With a zero divisor the
    // restoring divide leaves |S| as remainder and all-ones as quotient, so
    // the remainder correction reproduces S for HI.
    always_comb begin
        prod_mag = {acc, lo_acc};
        prod_fix = neg_q ? -prod_mag : prod_mag;
        quo_fix  = neg_q ? -lo_acc : lo_acc;
        rem_fix  = neg_r ? -acc : acc;
    end

    // Control FSM, datapath iteration and registered HI/LO/status outputs.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            skip_wr  <= 1'b0;
            acc      <= '0;
            lo_acc   <= '0;
            opb      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.dz   <= 1'b0;
            bus.HI   <= '0;
            bus.LO   <= '0;
        end else begin
            bus.done <= 1'b0;
            bus.dz   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.HI_wr) bus.HI <= bus.D;
                    if (bus.LO_wr) bus.LO <= bus.D;
                    if (bus.start) begin
                        is_div   <= bus.op[1];
                        neg_q    <= s_neg ^ t_neg;
                        neg_r    <= s_neg;
                        div_zero <= bus.op[1] && (bus.T == '0);
                        skip_wr  <= fast_dz;
                        acc      <= '0;
                        lo_acc   <= s_mag;
                        opb      <= t_mag;
                        count    <= CW'(WIDTH);
                        bus.busy <= 1'b1;
                        state    <= fast_dz ? FIX : RUN;
                    end
                end
                RUN: begin
                    if (is_div) begin
                        if (!div_diff[WIDTH]) begin
                            acc    <= div_diff[WIDTH-1:0];
                            lo_acc <= {lo_acc[WIDTH-2:0], 1'b1};
                        end else begin
                            acc    <= div_shift[WIDTH-1:0];
                            lo_acc <= {lo_acc[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc    <= mul_sum[WIDTH:1];
                        lo_acc <= {mul_sum[0], lo_acc[WIDTH-1:1]};
                    end
                    count <= count - 1'b1;
                    if (count == CW'(1)) state <= FIX;
                end
                FIX: begin
                    if (!skip_wr) begin
                        if (!is_div) begin
                            {bus.HI, bus.LO} <= prod_fix;
                        end else begin
                            bus.HI <= rem_fix;
                            bus.LO <= div_zero ? '1 : quo_fix;
                        end
                    end
                    bus.done <= 1'b1;
                    bus.dz   <= div_zero;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
